// File: rtl/edge_detect_debounce_if.sv
// Signal bundle for edge_detect_debounce: enable and raw levels in, debounced level and
// per-channel edge pulses out.
interface edge_detect_debounce_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic [WIDTH-1:0] level_in;
    logic [WIDTH-1:0] level_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] tick;
    logic             any_tick;

    modport master (
        output en,
        output level_in,
        input  level_out,
        input  rise,
        input  fall,
        input  tick,
        input  any_tick
    );

    modport slave (
        input  en,
        input  level_in,
        output level_out,
        output rise,
        output fall,
        output tick,
        output any_tick
    );
endinterface

// File: rtl/edge_detect_debounce.sv
// Multi-channel synchroniser + debouncer producing registered one-cycle rise/fall/tick pulses
// and the accepted (debounced) level of each channel.
module edge_detect_debounce #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 3,
    parameter int unsigned MODE            = 0
) (
    input logic                         clk,
    input logic                         rst_n,
    edge_detect_debounce_if.slave       bus
);

    localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);
    // MODE 3 is treated as "both edges".
    localparam bit RiseTick = (MODE != 1);
    localparam bit FallTick = (MODE != 0);

    typedef enum logic [1:0] {
        IdleLow,
        WaitHigh,
        IdleHigh,
        WaitLow
    } state_e;

    logic [WIDTH-1:0] tick_vec;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q;
        logic [SYNC_STAGES:0]   sync_chain;
        logic                   s;
        state_e                 state_q;
        logic [CntW-1:0]        cnt_q;
        logic [CntW-1:0]        cnt_inc;
        logic                   level_q;
        logic                   rise_q;
        logic                   fall_q;
        logic                   tick_q;

        assign sync_chain = {sync_q, bus.level_in[i]};
        assign s          = sync_q[SYNC_STAGES-1];
        assign cnt_inc    = cnt_q + CntW'(1);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= sync_chain[SYNC_STAGES-1:0];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IdleLow;
                cnt_q   <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                tick_q <= 1'b0;
                unique case (state_q)
                    IdleLow: begin
                        if (bus.en && s) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                state_q <= IdleHigh;
                                cnt_q   <= '0;
                                level_q <= 1'b1;
                                rise_q  <= 1'b1;
                                tick_q  <= RiseTick;
                            end else begin
                                state_q <= WaitHigh;
                                cnt_q   <= CntW'(1);
                            end
                        end
                    end
                    WaitHigh: begin
                        if (!bus.en || !s) begin
                            state_q <= IdleLow;
                            cnt_q   <= '0;
                        end else if (cnt_inc == CntMax) begin
                            state_q <= IdleHigh;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            rise_q  <= 1'b1;
                            tick_q  <= RiseTick;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    IdleHigh: begin
                        if (bus.en && !s) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                state_q <= IdleLow;
                                cnt_q   <= '0;
                                level_q <= 1'b0;
                                fall_q  <= 1'b1;
                                tick_q  <= FallTick;
                            end else begin
                                state_q <= WaitLow;
                                cnt_q   <= CntW'(1);
                            end
                        end
                    end
                    WaitLow: begin
                        if (!bus.en || s) begin
                            state_q <= IdleHigh;
                            cnt_q   <= '0;
                        end else if (cnt_inc == CntMax) begin
                            state_q <= IdleLow;
                            cnt_q   <= '0;
                            level_q <= 1'b0;
                            fall_q  <= 1'b1;
                            tick_q  <= FallTick;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                endcase
            end
        end

        assign bus.level_out[i] = level_q;
        assign bus.rise[i]      = rise_q;
        assign bus.fall[i]      = fall_q;
        assign bus.tick[i]      = tick_q;
        assign tick_vec[i]      = tick_q;
    end

    // OR of flop outputs only, so still no path from level_in.
    assign bus.any_tick = |tick_vec;

endmodule

// File: tb/tb_edge_detect_debounce.sv
// Directed bench for edge_detect_debounce: one MODE=0 and one MODE=2 instance share stimulus.
module tb_edge_detect_debounce;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] lvl;
    int         checks;
    int         errors;
    logic [3:0] r_or;
    logic [3:0] f_or;

    edge_detect_debounce_if #(.WIDTH(4)) bus0 ();
    edge_detect_debounce_if #(.WIDTH(4)) bus2 ();

    assign bus0.en       = en;
    assign bus0.level_in = lvl;
    assign bus2.en       = en;
    assign bus2.level_in = lvl;

    edge_detect_debounce #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(3), .MODE(0)
    ) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    edge_detect_debounce #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(3), .MODE(2)
    ) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accumulate rise/fall of the MODE=0 instance over n cycles.
    task automatic watch(input int n, output logic [3:0] ro, output logic [3:0] fo);
        ro = '0;
        fo = '0;
        for (int k = 0; k < n; k++) begin
            step();
            ro = ro | bus0.rise;
            fo = fo | bus0.fall;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        en     = 1'b1;
        lvl    = 4'b0000;

        // Reset state
        #2;
        chk("rst_level_out", 32'(bus0.level_out), 32'h0);
        chk("rst_rise", 32'(bus0.rise), 32'h0);
        chk("rst_fall", 32'(bus0.fall), 32'h0);
        chk("rst_tick", 32'(bus0.tick), 32'h0);
        chk("rst_any_tick", 32'(bus0.any_tick), 32'h0);
        step();
        step();
        rst_n = 1'b0;
        rst_n = 1'b1;
        step();
        step();

        // Channel 0 rising: pulse after 5th edge, level_out from same edge
        lvl[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("c0_rise_k%0d", k), 32'(bus0.rise), (k == 5) ? 32'h1 : 32'h0);
            chk($sformatf("c0_tick_k%0d", k), 32'(bus0.tick), (k == 5) ? 32'h1 : 32'h0);
            chk($sformatf("c0_any_k%0d", k), 32'(bus0.any_tick), (k == 5) ? 32'h1 : 32'h0);
            chk($sformatf("c0_lvl_k%0d", k), 32'(bus0.level_out), (k >= 5) ? 32'h1 : 32'h0);
        end

        // Channel 1 glitches: 1 period, 2 periods, sub-period between edges
        lvl[1] = 1'b1;
        step();
        lvl[1] = 1'b0;
        watch(8, r_or, f_or);
        chk("glitch1_rise", 32'(r_or[1]), 32'h0);
        chk("glitch1_lvl", 32'(bus0.level_out[1]), 32'h0);
        lvl[1] = 1'b1;
        step();
        step();
        lvl[1] = 1'b0;
        watch(8, r_or, f_or);
        chk("glitch2_rise", 32'(r_or[1]), 32'h0);
        chk("glitch2_lvl", 32'(bus0.level_out[1]), 32'h0);
        #1 lvl[1] = 1'b1;
        #2 lvl[1] = 1'b0;
        watch(8, r_or, f_or);
        chk("glitch_sub_rise", 32'(r_or[1]), 32'h0);
        chk("glitch_sub_tick", 32'(bus2.tick[1]), 32'h0);
        chk("glitch_sub_lvl", 32'(bus0.level_out), 32'h1);

        // Channel 2 high for 10 cycles: MODE=2 ticks on both edges, MODE=0 only on rise
        lvl[2] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("c2r_tick2_k%0d", k), 32'(bus2.tick[2]), (k == 5) ? 32'h1 : 32'h0);
            chk($sformatf("c2r_rise2_k%0d", k), 32'(bus2.rise[2]), (k == 5) ? 32'h1 : 32'h0);
            chk($sformatf("c2r_tick0_k%0d", k), 32'(bus0.tick[2]), (k == 5) ? 32'h1 : 32'h0);
        end
        lvl[2] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("c2f_tick2_k%0d", k), 32'(bus2.tick[2]), (k == 5) ? 32'h1 : 32'h0);
            chk($sformatf("c2f_fall2_k%0d", k), 32'(bus2.fall[2]), (k == 5) ? 32'h1 : 32'h0);
            chk($sformatf("c2f_tick0_k%0d", k), 32'(bus0.tick[2]), 32'h0);
            chk($sformatf("c2f_fall0_k%0d", k), 32'(bus0.fall[2]), (k == 5) ? 32'h1 : 32'h0);
            chk($sformatf("c2f_lvl_k%0d", k), 32'(bus0.level_out[2]), (k >= 5) ? 32'h0 : 32'h1);
        end

        // Channel 3 bounce: samples 1,0,1,1,1 -> single rise after the 7th edge
        lvl[3] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("c3_rise_k%0d", k), 32'(bus0.rise), (k == 7) ? 32'h8 : 32'h0);
            if (k == 1) lvl[3] = 1'b0;
            if (k == 2) lvl[3] = 1'b1;
        end
        chk("c3_lvl", 32'(bus0.level_out), 32'h9);

        // Enable: ch0 goes low then rises while en=0, accepted 3 cycles after en=1
        lvl[0] = 1'b0;
        watch(8, r_or, f_or);
        chk("c0_fall_seen", 32'(f_or), 32'h1);
        en     = 1'b0;
        lvl[0] = 1'b1;
        watch(10, r_or, f_or);
        chk("en0_no_rise", 32'(r_or), 32'h0);
        chk("en0_no_any", 32'(bus0.any_tick), 32'h0);
        chk("en0_lvl", 32'(bus0.level_out), 32'h8);
        en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("en1_rise_k%0d", k), 32'(bus0.rise), (k == 3) ? 32'h1 : 32'h0);
        end
        chk("en1_lvl", 32'(bus0.level_out), 32'h9);

        // Async reset mid-WAIT_HIGH on channel 1
        lvl[1] = 1'b1;
        step();
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_lvl", 32'(bus0.level_out), 32'h0);
        chk("arst_rise", 32'(bus0.rise), 32'h0);
        chk("arst_any", 32'(bus2.any_tick), 32'h0);
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("arst_rise_k%0d", k), 32'(bus0.rise), (k == 5) ? 32'hb : 32'h0);
            chk($sformatf("arst_any_k%0d", k), 32'(bus0.any_tick), (k == 5) ? 32'h1 : 32'h0);
        end

        // All four channels rising together
        lvl = 4'b0000;
        watch(8, r_or, f_or);
        chk("all_fall_seen", 32'(f_or), 32'hb);
        lvl = 4'b1111;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("all_rise_k%0d", k), 32'(bus0.rise), (k == 5) ? 32'hf : 32'h0);
            chk($sformatf("all_tick2_k%0d", k), 32'(bus2.tick), (k == 5) ? 32'hf : 32'h0);
            chk($sformatf("all_any_k%0d", k), 32'(bus0.any_tick), (k == 5) ? 32'h1 : 32'h0);
        end
        chk("all_lvl", 32'(bus0.level_out), 32'hf);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
